// File: rtl/async_reg_bank_pkg.sv
// Shared types and constants for the asynchronous-strobe register bank.
// Latency: none (definitions only).
// Backpressure: none (definitions only).
package async_reg_pkg;

    localparam int ERR_CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        COMMIT  = 2'd2,
        HOLD    = 2'd3
    } state_t;

    // Ceiling log2, usable in constant expressions.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/async_reg_bank_if.sv
// Strobe-bus bundle between an external bus host and the register bank.
// Latency: none (wiring only).
// Backpressure: none; the strobe protocol is open-loop and timing-bounded.
interface async_reg_bank_if #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 24,
    parameter int STATUS_W = 8
);
    logic [ADDR_W-1:0]   address;
    logic [DATA_W-1:0]   data_in;
    logic [DATA_W/8-1:0] be;
    logic                ws_n;
    logic                rs_n;
    logic                as;
    logic [DATA_W-1:0]   data_out;
    logic                rd_valid;
    logic [STATUS_W-1:0] status_out;
    logic                err;

    modport master (
        output address, data_in, be, ws_n, rs_n, as,
        input  data_out, rd_valid, status_out, err
    );

    modport slave (
        input  address, data_in, be, ws_n, rs_n, as,
        output data_out, rd_valid, status_out, err
    );
endinterface

// File: rtl/async_reg_bank_sync_chain.sv
// Multi-bit flop synchroniser with a per-bit "all stages agree" qualifier.
// Latency: STAGES clk edges from input sample to q.
// Backpressure: none; free-running every clk.
module sync_chain #(
    parameter int               WIDTH   = 1,
    parameter int               STAGES  = 2,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] stable
);

    logic [WIDTH-1:0] stage [STAGES];

    // Shift the asynchronous inputs through the chain; reset to inactive levels.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < STAGES; i++) stage[i] <= RST_VAL;
        end else begin
            stage[0] <= d;
            for (int i = 1; i < STAGES; i++) stage[i] <= stage[i-1];
        end
    end

    assign q = stage[STAGES-1];

    // A bit is stable when every stage holds the same value as the output stage,
    // so a level shorter than STAGES samples is never reported as settled.
    always_comb begin
        stable = '1;
        for (int i = 0; i < STAGES - 1; i++) stable = stable & ~(stage[i] ^ stage[STAGES-1]);
    end

endmodule

// File: rtl/async_reg_bank.sv
// Strobe-bus register bank: synchronise strobes, capture/commit one access per assertion; optional error tracking under ASYNC_REG_ERR_EN.
// Latency: access performed SYNC_STAGES+2 clk edges after the first edge sampling the strobe.
// Backpressure: none; host must respect minimum strobe-low and strobe-high times of SYNC_STAGES+1 clk periods.
module async_reg_bank
    import async_reg_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 24,
    parameter int N_REGS      = 16,
    parameter int SYNC_STAGES = 3,
    parameter int STATUS_W    = 8
) (
    input logic            clk,
    input logic            rst,
    async_reg_bank_if.slave bus
);

    localparam int IDX_W = clog2(N_REGS);
    localparam int LANES = DATA_W / 8;

    state_t state, state_nxt;
    logic   start, capture_en, commit_en;

    logic [2:0] sync_q, sync_stable;
    logic       ws_act, rs_act, as_act, ws_rel, rs_rel;

    logic [SYNC_STAGES-1:0] prime_sr;
    logic                   primed;

    logic [IDX_W-1:0]  cap_idx;
    logic              cap_in_range, cap_wr, cap_rd;
    logic [DATA_W-1:0] cap_data;
    logic [LANES-1:0]  cap_be;

    logic [DATA_W-1:0] regs [N_REGS];
    logic [LANES-1:0]  lane_wr;
    logic [DATA_W-1:0] rd_word;
    logic [DATA_W-1:0] data_out_q;
    logic              rd_valid_q;

    logic              in_range;
    logic [IDX_W-1:0]  idx;

    // Inactive levels: as = 0, rs_n = 1, ws_n = 1.
    sync_chain #(
        .WIDTH   (3),
        .STAGES  (SYNC_STAGES),
        .RST_VAL (3'b011)
    ) u_sync (
        .clk    (clk),
        .rst    (rst),
        .d      ({bus.as, bus.rs_n, bus.ws_n}),
        .q      (sync_q),
        .stable (sync_stable)
    );

    assign ws_act = ~sync_q[0] &  sync_stable[0];
    assign ws_rel =  sync_q[0] &  sync_stable[0];
    assign rs_act = ~sync_q[1] &  sync_stable[1];
    assign rs_rel =  sync_q[1] &  sync_stable[1];
    assign as_act =  sync_q[2] &  sync_stable[2];

    // Mark when the chain has been refilled with post-reset samples, so a strobe
    // held low across reset is seen as held rather than as a fresh release.
    always_ff @(posedge clk) begin
        if (rst) prime_sr <= '0;
        else     prime_sr <= {prime_sr[SYNC_STAGES-2:0], 1'b1};
    end
    assign primed = prime_sr[SYNC_STAGES-1];

    assign idx      = bus.address[2 +: IDX_W];
    assign in_range = ((bus.address >> (2 + IDX_W)) == '0);
    assign start    = as_act & (ws_act | rs_act);

    // State register; reset parks in HOLD until the strobes are seen released.
    always_ff @(posedge clk) begin
        if (rst) state <= HOLD;
        else     state <= state_nxt;
    end

    // Next-state: a single pass through CAPTURE and COMMIT per strobe assertion.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = CAPTURE;
            CAPTURE: state_nxt = COMMIT;
            COMMIT:  state_nxt = HOLD;
            HOLD:    if (primed && ws_rel && rs_rel) state_nxt = IDLE;
            default: state_nxt = HOLD;
        endcase
    end

    // FSM outputs: capture strobe on IDLE exit, commit strobe in COMMIT.
    always_comb begin
        capture_en = 1'b0;
        commit_en  = 1'b0;
        case (state)
            IDLE:    capture_en = start;
            COMMIT:  commit_en  = 1'b1;
            default: ;
        endcase
    end

    // Latch the access once the strobes are settled; write wins over read.
    always_ff @(posedge clk) begin
        if (rst) begin
            cap_idx      <= '0;
            cap_in_range <= 1'b0;
            cap_data     <= '0;
            cap_be       <= '0;
            cap_wr       <= 1'b0;
            cap_rd       <= 1'b0;
        end else if (capture_en) begin
            cap_idx      <= idx;
            cap_in_range <= in_range;
            cap_data     <= bus.data_in;
            cap_be       <= bus.be;
            cap_wr       <= ws_act;
            cap_rd       <= rs_act & ~ws_act;
        end
    end

`ifdef ASYNC_REG_ERR_EN
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_REGS - 1);

    logic                 cap_both;
    logic                 err_q;
    logic [ERR_CNT_W-1:0] err_cnt;

    // Remember a simultaneous write+read request for error reporting.
    always_ff @(posedge clk) begin
        if (rst)             cap_both <= 1'b0;
        else if (capture_en) cap_both <= ws_act & rs_act;
    end

    // Sticky error flag and saturating count of erroneous accesses.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q   <= 1'b0;
            err_cnt <= '0;
        end else if (commit_en && (!cap_in_range || cap_both)) begin
            err_q <= 1'b1;
            if (err_cnt != '1) err_cnt <= err_cnt + 1'b1;
        end
    end

    assign bus.err = err_q;
`else
    assign bus.err = 1'b0;
`endif

    // Byte lanes written at commit; the counter lane of the last register is read-only when present.
    always_comb begin
        lane_wr = '0;
        if (commit_en && cap_wr && cap_in_range) lane_wr = cap_be;
`ifdef ASYNC_REG_ERR_EN
        if (cap_idx == LAST_IDX) lane_wr[LANES-1] = 1'b0;
`endif
    end

    // Register file update, one byte lane at a time.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < N_REGS; r++) regs[r] <= '0;
        end else begin
            for (int l = 0; l < LANES; l++) begin
                if (lane_wr[l]) regs[cap_idx][l*8 +: 8] <= cap_data[l*8 +: 8];
            end
        end
    end

    // Read view of the addressed register, with the error count overlaid when present.
    always_comb begin
        rd_word = regs[cap_idx];
`ifdef ASYNC_REG_ERR_EN
        if (cap_idx == LAST_IDX) rd_word[DATA_W-1 -: ERR_CNT_W] = err_cnt;
`endif
    end

    // Read data is held until the next read; out-of-range reads return zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_out_q <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= commit_en & cap_rd;
            if (commit_en && cap_rd) data_out_q <= cap_in_range ? rd_word : '0;
        end
    end

    assign bus.data_out   = data_out_q;
    assign bus.rd_valid   = rd_valid_q;
    assign bus.status_out = regs[0][STATUS_W-1:0];

endmodule

// File: tb/tb_async_reg_bank.sv
// Randomised and directed bench for async_reg_bank against a latency-based access model.
// Latency: model applies each access S+3 negedges after the strobe is driven.
// Backpressure: strobes are driven with legal low/high times.
module tb_async_reg_bank;

    localparam int S  = 3;
    localparam int NR = 16;
`ifdef ASYNC_REG_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    async_reg_bank_if bus ();

    async_reg_bank dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int checks = 0;
    int errors = 0;
    int unsigned cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int unsigned at;
        bit          wr;
        bit          rd;
        logic [23:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
    } ev_t;

    ev_t         evq[$];
    logic [31:0] m_regs [NR];
    logic [31:0] m_dout;
    bit          m_err;
    int          m_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < NR; i++) m_regs[i] = 32'h0;
        m_dout = 32'h0;
        m_err  = 1'b0;
        m_cnt  = 0;
    endfunction

    function automatic logic [31:0] model_read(input logic [23:0] a);
        int idx;
        idx = int'(a[5:2]);
        if (a[23:6] != 18'h0) return 32'h0;
        if (ERR_EN && idx == NR - 1) return {m_cnt[7:0], m_regs[idx][23:0]};
        return m_regs[idx];
    endfunction

    function automatic void model_apply(input ev_t e);
        bit inr;
        int idx;
        inr = (e.addr[23:6] == 18'h0);
        idx = int'(e.addr[5:2]);
        if (e.wr && inr) begin
            for (int b = 0; b < 4; b++) begin
                if (e.be[b] && !(ERR_EN && idx == NR - 1 && b == 3))
                    m_regs[idx][b*8 +: 8] = e.data[b*8 +: 8];
            end
        end
        if (!e.wr && e.rd) m_dout = model_read(e.addr);
        if (ERR_EN && (!inr || (e.wr && e.rd))) begin
            m_err = 1'b1;
            if (m_cnt < 255) m_cnt++;
        end
    endfunction

    // Per-cycle compare of every output against the model.
    initial begin
        ev_t e;
        bit  exp_rdv;
        forever begin
            @(negedge clk);
            if (!rst) begin
                exp_rdv = 1'b0;
                if (evq.size() > 0 && evq[0].at == cyc) begin
                    e = evq.pop_front();
                    model_apply(e);
                    exp_rdv = !e.wr && e.rd;
                end
                chk("rd_valid", {31'h0, bus.rd_valid}, {31'h0, exp_rdv});
                chk("data_out", bus.data_out, m_dout);
                chk("status_out", {24'h0, bus.status_out}, {24'h0, m_regs[0][7:0]});
                chk("err", {31'h0, bus.err}, {31'h0, m_err});
            end
        end
    end

    task automatic idle_bus();
        bus.ws_n = 1'b1;
        bus.rs_n = 1'b1;
        bus.as   = 1'b0;
    endtask

    // One strobe assertion of 'hold' cycles followed by 'gap' idle cycles.
    task automatic access(input bit wr, input bit rd, input logic [23:0] a, input logic [31:0] d,
                          input logic [3:0] b, input int hold, input int gap);
        ev_t e;
        bus.address = a;
        bus.data_in = d;
        bus.be      = b;
        bus.as      = 1'b1;
        bus.ws_n    = !wr;
        bus.rs_n    = !rd;
        if (hold >= S + 1 && (wr || rd)) begin
            e.at = cyc + S + 3;
            e.wr = wr; e.rd = rd; e.addr = a; e.data = d; e.be = b;
            evq.push_back(e);
        end
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (i == S + 4) begin
                bus.data_in = $urandom;
                bus.be      = 4'($urandom);
            end
        end
        idle_bus();
        repeat (gap) @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        model_reset();
        evq.delete();
        rst = 1'b0;
        repeat (S + 3) @(negedge clk);
    endtask

    initial begin
        int          kind;
        logic [23:0] a;
        idle_bus();
        bus.address = '0;
        bus.data_in = '0;
        bus.be      = '0;
        model_reset();
        @(negedge clk);
        do_reset();

        chk("reset_data_out", bus.data_out, 32'h0);
        chk("reset_rd_valid", {31'h0, bus.rd_valid}, 32'h0);
        chk("reset_status", {24'h0, bus.status_out}, 32'h0);
        chk("reset_err", {31'h0, bus.err}, 32'h0);

        access(1, 0, 24'h000008, 32'hDEADBEEF, 4'b1111, S + 2, S + 3);
        access(1, 0, 24'h000008, 32'h00001200, 4'b0010, S + 2, S + 3);
        access(0, 1, 24'h000008, 32'h0, 4'h0, S + 2, S + 3);
        chk("byte_enable_read", bus.data_out, 32'hDEAD12EF);

        access(1, 0, 24'h000000, 32'h000000A5, 4'b1111, S + 1, S + 3);
        chk("status_a5", {24'h0, bus.status_out}, 32'h000000A5);

        access(1, 0, 24'h000004, 32'h11223344, 4'b1111, 50, S + 3);
        access(0, 1, 24'h000004, 32'h0, 4'h0, S + 2, S + 3);
        chk("long_strobe_one_write", bus.data_out, 32'h11223344);

        access(1, 0, 24'h000040, 32'hFFFFFFFF, 4'b1111, S + 2, S + 3);
        chk("oor_write_err", {31'h0, bus.err}, {31'h0, ERR_EN});
        access(0, 1, 24'h00003C, 32'h0, 4'h0, S + 2, S + 3);
        chk("err_counter_read", bus.data_out, ERR_EN ? 32'h01000000 : 32'h0);
        access(0, 1, 24'h000040, 32'h0, 4'h0, S + 2, S + 3);
        chk("oor_read_zero", bus.data_out, 32'h0);

        access(1, 0, 24'h000000, 32'h00000033, 4'b1111, S - 1, S + 3);
        chk("short_pulse_dropped", {24'h0, bus.status_out}, 32'h000000A5);

        access(1, 1, 24'h000010, 32'hCAFEF00D, 4'b1111, S + 2, S + 3);
        access(0, 1, 24'h000010, 32'h0, 4'h0, S + 2, S + 3);
        chk("both_strobes_write", bus.data_out, 32'hCAFEF00D);

        // Strobe held low through reset release must not produce an access.
        bus.address = 24'h000000;
        bus.data_in = 32'h00000077;
        bus.be      = 4'b1111;
        bus.as      = 1'b1;
        bus.ws_n    = 1'b0;
        do_reset();
        repeat (25) @(negedge clk);
        chk("held_through_reset", {24'h0, bus.status_out}, 32'h0);
        idle_bus();
        repeat (S + 3) @(negedge clk);
        access(1, 0, 24'h000000, 32'h0000005A, 4'b1111, S + 2, S + 3);
        chk("after_reset_write", {24'h0, bus.status_out}, 32'h0000005A);

        for (int n = 0; n < 150; n++) begin
            kind = $urandom_range(0, 7);
            if ($urandom_range(0, 7) == 0) a = 24'($urandom) | 24'h000040;
            else                           a = 24'($urandom) & 24'h00003F;
            case (kind)
                0, 1, 2: access(1, 0, a, $urandom, 4'($urandom), $urandom_range(S + 1, S + 8), $urandom_range(S + 2, S + 6));
                3, 4, 5: access(0, 1, a, $urandom, 4'($urandom), $urandom_range(S + 1, S + 8), $urandom_range(S + 2, S + 6));
                6:       access(1, 1, a, $urandom, 4'($urandom), $urandom_range(S + 1, S + 8), $urandom_range(S + 2, S + 6));
                default: access(1, 0, a, $urandom, 4'($urandom), S - 1, $urandom_range(S + 2, S + 6));
            endcase
        end

        for (int i = 0; i < 100 && evq.size() > 0; i++) @(negedge clk);
        if (evq.size() > 0) chk("pending_events", evq.size(), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/async_reg_bank.md
# async_reg_bank

Parametrised bus-slave register bank for the external ARM-style strobe bus, clocked by a much faster local `clk`. It synchronises the asynchronous strobes and chip select through a configurable-depth synchroniser and edge-qualifies them, so each strobe assertion produces exactly one access. Accesses run through a capture/commit state machine into an N-word register file with byte enables. It drives a generalised status output from register 0 and replaces the fixed 8-register, 4-stage bank in the host-interface path.

## Interface
- `DATA_W`, default 32: register and bus data width; must be a multiple of 8.
- `ADDR_W`, default 24: bus byte-address width.
- `N_REGS`, default 16: number of registers; must be a power of two, ≥2.
- `SYNC_STAGES`, default 3: synchroniser depth for `ws_n`, `rs_n` and `as`; must be ≥2.
- `STATUS_W`, default 8: width of `status_out`; must be ≤`DATA_W`.

Ports:
- `clk`  in  1  local clock.
- `rst`  in  1  reset. Synchronous, active-high.
- `address`  in  ADDR_W  bus byte address; stable while a strobe is asserted.
- `data_in`  in  DATA_W  bus write data.
- `be`  in  DATA_W/8  byte enables, active-high.
- `ws_n`  in  1  write strobe, active-low, asynchronous.
- `rs_n`  in  1  read strobe, active-low, asynchronous.
- `as`  in  1  chip select, active-high, asynchronous.
- `data_out`  out  DATA_W  read data, held until the next read.
- `rd_valid`  out  1  one-cycle pulse when `data_out` updates.
- `status_out`  out  STATUS_W  `reg[0][STATUS_W-1:0]`.
- `err`  out  1  sticky error flag; see Configuration.

## Operation
- Register index: `idx = address[2 +: IDX_W]`, where `IDX_W = log2(N_REGS)`.
- In range when `address[ADDR_W-1 : 2+IDX_W] == 0`.
- `address[1:0]` is ignored.

State machine states: IDLE, CAPTURE, COMMIT, HOLD.
- IDLE → CAPTURE when `as_s` is high and either `ws_s` or `rs_s` is low (`_s` = synchronised). On that edge, latch `address`, `data_in`, `be`, the operation and the range check.
- Operation priority: if both strobes are low, the access is a write and the read is dropped.
- CAPTURE → COMMIT unconditionally.
- COMMIT → HOLD unconditionally; the access is performed on this edge.
  - Write: each enabled byte lane of `reg[idx]` is updated; disabled lanes are unchanged.
  - Read: `data_out` ← `reg[idx]` and `rd_valid` pulses.
- HOLD → IDLE when `ws_s` and `rs_s` are both high. This gives exactly one access per strobe assertion regardless of strobe length.
- Out-of-range write: dropped.
- Out-of-range read: `data_out` ← 0 and `rd_valid` still pulses.
- Strobe or `as` deasserting during CAPTURE or COMMIT: the latched access still completes.
- Reset values:
  - All registers = 0; `data_out` = 0; `rd_valid` = 0; `status_out` = 0; `err` = 0.
  - Synchroniser flops = inactive (`ws_n`/`rs_n` = 1, `as` = 0).
  - State = HOLD. A strobe held low across reset release therefore produces no access until it is released and reasserted.
- Reset asserted mid-access aborts the access; no partial write occurs.

## Timing
- Let edge k be the first `clk` edge that samples the asserted strobe into the synchroniser.
- `ws_s`/`rs_s` are valid after edge k+S-1, where S = `SYNC_STAGES`.
- CAPTURE is entered at edge k+S.
- The write is visible in the register, and `status_out` updates, after edge k+S+2.
- `data_out` and `rd_valid` update at edge k+S+2; `rd_valid` is high for exactly one cycle.
- Minimum strobe-low time for a guaranteed access: S+1 `clk` periods.
- Minimum strobe-high gap between accesses: S+1 `clk` periods.
- Address, data and byte enables must be stable from strobe assertion until edge k+S. They are not synchronised and are sampled only once the strobes are stable.

## Configuration
- Macro `ASYNC_REG_ERR_EN`.
- Defined:
  - `err` sets on any out-of-range access, or on a simultaneous write and read strobe, at the COMMIT edge.
  - `err` stays set until `rst`.
  - An internal 8-bit saturating error counter is readable as the upper byte of `reg[N_REGS-1]` on reads. Writes to that byte lane are ignored.
- Not defined:
  - `err` is tied to 0 and no counter exists.
  - `reg[N_REGS-1]` is a plain read/write register.
  - All other behaviour is identical.

## Structure
- Package `async_reg_pkg`:
  - state enum (IDLE, CAPTURE, COMMIT, HOLD);
  - a `clog2` function;
  - the `ERR_CNT_W = 8` constant.
- Sub-module `sync_chain`:
  - parameters: width and stages;
  - reset value is a parameter;
  - instantiated once, 3 bits wide, for `{as, rs_n, ws_n}`.
- Top-level logic: state machine, capture registers, register array, error logic.

## Test plan
- Reset then idle: all outputs 0; `status_out` = 0; state HOLD → IDLE once strobes are observed high.
- Write `0xDEADBEEF` to address `0x000008` with `be` = 4'b1111, then `be` = 4'b0010 with data `0x00001200` → a read of `0x000008` returns `0xDEAD12EF`; `rd_valid` pulses once, S+2 edges after the first sampling edge.
- Write `0x000000A5` to address `0x000000` → `status_out` = `0xA5` after edge k+S+2.
- Write strobe held low for 50 cycles, with data changed only after commit → exactly one write.
- Out-of-range write to `0x000040` (N_REGS = 16) → no register changes. With `ASYNC_REG_ERR_EN`, `err` = 1 and the counter = 1; without it, `err` = 0.
- Strobe pulse of S-1 cycles → no access.
- Strobe held low through reset release → no access until it goes high and then low again.
- Both strobes low at once → the write is performed and `rd_valid` stays 0.
